four_way_demux_component: RTL

FOUR_WAY_DEMUX_COMPONENT -- requirements
Module: four_way_demux_component

---
 rtl/four_way_demux_component.sv | 103 ++++++++++
 1 files changed

// File: rtl/four_way_demux_component.sv
// Four-lane demultiplexer: each lane is a one-entry buffer with an EMPTY/FULL FSM.
// Optional delivered-word counter (stat_count) is built when DEMUX_STATS_EN is defined.
module four_way_demux_component #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      stat_count
`endif
);

    // Handshake: a word moves on a port only in a cycle where valid && ready.
    // in_ready looks at lane[op] only, so a blocked lane never stalls the others.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t      state_q [4];
    lane_state_t      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [3:0]       deliver;
    logic             accept;

    assign in_ready = !reset && ((state_q[op] == EMPTY) || out_ready[op]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            data_d[n]  = data_q[n];
            deliver[n] = (state_q[n] == FULL) && out_ready[n];
            // An accept on the same edge as a deliver wins: lane stays FULL with the new word.
            if (accept && (op == 2'(n))) begin
                state_d[n] = FULL;
                data_d[n]  = in;
            end else if (deliver[n]) begin
                state_d[n] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (reset) begin
                state_q[n] <= EMPTY;
                data_q[n]  <= '0;
            end else begin
                state_q[n] <= state_d[n];
                data_q[n]  <= data_d[n];
            end
        end
    end

    assign out0 = data_q[0];
    assign out1 = data_q[1];
    assign out2 = data_q[2];
    assign out3 = data_q[3];

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            out_valid[n] = (state_q[n] == FULL);
        end
    end

`ifdef DEMUX_STATS_EN
    logic [2:0]  ndeliv;
    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        ndeliv = 3'd0;
        for (int n = 0; n < 4; n++) begin
            ndeliv = ndeliv + {2'b00, deliver[n]};
        end
        count_d = count_q + {13'd0, ndeliv};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign stat_count = count_q;
`endif

endmodule
